// File: rtl/csi_rx_pkg.sv
// Shared types and constants for the CSI-2 receive lane front end.
package csi_rx_pkg;

  // HS leader sync pattern, LSB is the oldest bit on the wire.
  localparam logic [7:0] CSI_SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    ALN_IDLE   = 2'd0,
    ALN_HUNT   = 2'd1,
    ALN_LOCKED = 2'd2
  } align_state_t;

  typedef logic [2:0] bit_offset_t;

  // True when every window bit below position k is zero (HS-zero leader).
  function automatic logic leader_is_zero(input logic [15:0] win, input int k);
    logic [15:0] mask;
    mask = (16'd1 << k) - 16'd1;
    return ((win & mask) == 16'd0);
  endfunction

endpackage

// File: rtl/csi_rx_sync_detect.sv
// Combinational sync-byte matcher over a 16-bit window; lowest offset wins.
module csi_rx_sync_detect
  import csi_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = CSI_SYNC_BYTE,
  parameter logic       CHECK_LEADER = 1'b1
) (
  input  logic [15:0] window,
  output logic        hit,
  output logic [2:0]  k
);

  logic [7:0] match_s;

  // Evaluate every candidate offset independently.
  always_comb begin
    match_s = 8'd0;
    for (int i = 0; i < 8; i++) begin
      match_s[i] = (window[i +: 8] == SYNC_BYTE) &&
                   (!CHECK_LEADER || leader_is_zero(window, i));
    end
  end

  // Scan from the top down so the lowest matching offset is the one kept.
  always_comb begin
    hit = |match_s;
    k   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      k = match_s[i] ? bit_offset_t'(i) : k;
    end
  end

endmodule

// File: rtl/csi_rx_byte_align.sv
// Per-lane CSI-2 byte aligner: hunts for the HS sync byte at any bit offset,
// locks that offset and emits aligned payload bytes until end of packet.
module csi_rx_byte_align
  import csi_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = CSI_SYNC_BYTE,
  parameter logic        CHECK_LEADER = 1'b1,
  parameter int unsigned HUNT_TIMEOUT = 1023
) (
  input  logic       byte_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       wait_for_sync,
  input  logic       packet_done,
  input  logic [7:0] deser_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic [2:0] offset,
  output logic       hunt_timeout
);

  localparam int unsigned       CNT_W   = $clog2(HUNT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HUNT_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  align_state_t     state_q, state_d;
  logic [7:0]       r0_q, r0_d, r1_q, r1_d;
  bit_offset_t      offset_q, offset_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             locked_q, locked_d;
  logic             hunt_timeout_q, hunt_timeout_d;

  logic [15:0]      window_s;
  logic             hit_s;
  bit_offset_t      k_s;
  logic [7:0]       aligned_s;

  assign window_s  = {r1_q, r0_q};
  assign aligned_s = window_s[offset_q +: 8];

  csi_rx_sync_detect #(
    .SYNC_BYTE    (SYNC_BYTE),
    .CHECK_LEADER (CHECK_LEADER)
  ) u_sync_detect (
    .window (window_s),
    .hit    (hit_s),
    .k      (k_s)
  );

  // Next-state, hunt counter and output computation; exits beat matches.
  always_comb begin
    state_d        = state_q;
    offset_d       = offset_q;
    cnt_d          = cnt_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    hunt_timeout_d = 1'b0;
    r1_d           = deser_in;
    r0_d           = r1_q;

    if (!enable) begin
      state_d = ALN_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ALN_IDLE: begin
          cnt_d = '0;
          if (wait_for_sync) begin
            state_d = ALN_HUNT;
          end else begin
            state_d = ALN_IDLE;
          end
        end
        ALN_HUNT: begin
          if (!wait_for_sync) begin
            state_d = ALN_IDLE;
          end else if (hit_s) begin
            state_d  = ALN_LOCKED;
            offset_d = k_s;
          end else if (cnt_q == CNT_MAX) begin
            hunt_timeout_d = 1'b1;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ALN_LOCKED: begin
          if (packet_done) begin
            state_d = ALN_IDLE;
          end else begin
            data_valid_d = 1'b1;
            data_out_d   = aligned_s;
          end
        end
        default: begin
          state_d = ALN_IDLE;
        end
      endcase
    end

    // locked tracks the state register itself, so it drops on the exit edge.
    locked_d = (state_d == ALN_LOCKED);
  end

  // State, pipeline and output registers with synchronous reset.
  always_ff @(posedge byte_clock) begin
    if (reset) begin
      state_q        <= ALN_IDLE;
      r0_q           <= 8'd0;
      r1_q           <= 8'd0;
      offset_q       <= 3'd0;
      cnt_q          <= '0;
      data_out_q     <= 8'd0;
      data_valid_q   <= 1'b0;
      locked_q       <= 1'b0;
      hunt_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      r0_q           <= r0_d;
      r1_q           <= r1_d;
      offset_q       <= offset_d;
      cnt_q          <= cnt_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      locked_q       <= locked_d;
      hunt_timeout_q <= hunt_timeout_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign locked       = locked_q;
  assign offset       = offset_q;
  assign hunt_timeout = hunt_timeout_q;

endmodule
